// File: rtl/glitch_scheduler.sv
// Fault-injection campaign scheduler: after a trigger, waits a programmed delay,
// then emits a train of glitch pulses on one of two registered injector enables.
module glitch_scheduler #(
    parameter int DELAY_W = 16,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [LEN_W-1:0]   cfg_gap,
    input  logic [LEN_W-1:0]   cfg_count,
    input  logic               cfg_mode,
    input  logic               trigger,
    input  logic               abort,
    output logic               glitch_enable,
    output logic               glitch_enable_specific,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   pulse_idx,
    output logic [2:0]         fsm_state
);

    // Config handshake: a configuration is taken on any rising edge where
    // cfg_valid and cfg_ready are both high; cfg_ready is high only in IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        DELAY  = 3'd2,
        GLITCH = 3'd3,
        GAP    = 3'd4
    } state_t;

    state_t             state;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] delay_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   gap_q;
    logic [LEN_W-1:0]   count_q;
    logic [LEN_W-1:0]   len_cnt;
    logic               mode_q;
    logic [LEN_W-1:0]   pulse_next;

    assign pulse_next = pulse_idx + LEN_W'(1);
    assign cfg_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    // Counters count down to zero and stop, so no field value can wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            delay_q                <= '0;
            delay_cnt              <= '0;
            len_q                  <= '0;
            gap_q                  <= '0;
            count_q                <= '0;
            len_cnt                <= '0;
            mode_q                 <= 1'b0;
            pulse_idx              <= '0;
            done                   <= 1'b0;
            glitch_enable          <= 1'b0;
            glitch_enable_specific <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state                  <= IDLE;
                glitch_enable          <= 1'b0;
                glitch_enable_specific <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_valid) begin
                            delay_q   <= cfg_delay;
                            len_q     <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                            gap_q     <= cfg_gap;
                            count_q   <= (cfg_count == '0) ? LEN_W'(1) : cfg_count;
                            mode_q    <= cfg_mode;
                            pulse_idx <= '0;
                            state     <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (trigger) begin
                            delay_cnt <= delay_q;
                            state     <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (delay_cnt == '0) begin
                            state                  <= GLITCH;
                            len_cnt                <= len_q - LEN_W'(1);
                            glitch_enable          <= ~mode_q;
                            glitch_enable_specific <= mode_q;
                        end else begin
                            delay_cnt <= delay_cnt - DELAY_W'(1);
                        end
                    end
                    GLITCH: begin
                        if (len_cnt == '0) begin
                            pulse_idx <= pulse_next;
                            if (pulse_next == count_q) begin
                                state                  <= IDLE;
                                done                   <= 1'b1;
                                glitch_enable          <= 1'b0;
                                glitch_enable_specific <= 1'b0;
                            end else if (gap_q == '0) begin
                                // Zero gap: reload and keep the enable high.
                                len_cnt <= len_q - LEN_W'(1);
                            end else begin
                                state                  <= GAP;
                                len_cnt                <= gap_q - LEN_W'(1);
                                glitch_enable          <= 1'b0;
                                glitch_enable_specific <= 1'b0;
                            end
                        end else begin
                            len_cnt <= len_cnt - LEN_W'(1);
                        end
                    end
                    GAP: begin
                        if (len_cnt == '0) begin
                            state                  <= GLITCH;
                            len_cnt                <= len_q - LEN_W'(1);
                            glitch_enable          <= ~mode_q;
                            glitch_enable_specific <= mode_q;
                        end else begin
                            len_cnt <= len_cnt - LEN_W'(1);
                        end
                    end
                    default: begin
                        state                  <= IDLE;
                        glitch_enable          <= 1'b0;
                        glitch_enable_specific <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_scheduler.sv
// Bench for glitch_scheduler: directed campaigns plus random ones, each cycle
// compared against a pulse-train timeline computed from the campaign parameters.
module tb_glitch_scheduler;

    localparam int DW = 16;
    localparam int LW = 8;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_delay;
    logic [LW-1:0] cfg_len;
    logic [LW-1:0] cfg_gap;
    logic [LW-1:0] cfg_count;
    logic          cfg_mode;
    logic          trigger;
    logic          abort;
    logic          glitch_enable;
    logic          glitch_enable_specific;
    logic          busy;
    logic          done;
    logic [LW-1:0] pulse_idx;
    logic [2:0]    fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Timeline of the campaign under test, in absolute edge numbers.
    int m_k, m_d, m_le, m_g, m_ce, m_mode, m_end, m_stop;

    glitch_scheduler #(.DELAY_W(DW), .LEN_W(LW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_delay              (cfg_delay),
        .cfg_len                (cfg_len),
        .cfg_gap                (cfg_gap),
        .cfg_count              (cfg_count),
        .cfg_mode               (cfg_mode),
        .trigger                (trigger),
        .abort                  (abort),
        .glitch_enable          (glitch_enable),
        .glitch_enable_specific (glitch_enable_specific),
        .busy                   (busy),
        .done                   (done),
        .pulse_idx              (pulse_idx),
        .fsm_state              (fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input int exp_pi);
        chk({tag, ".ge"},    32'(glitch_enable), 0);
        chk({tag, ".gs"},    32'(glitch_enable_specific), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(done), 0);
        chk({tag, ".ready"}, 32'(cfg_ready), 1);
        chk({tag, ".idx"},   32'(pulse_idx), 32'(exp_pi));
    endtask

    // Pulse p covers edges [s, s+len) with s = k+1+delay+p*(len+gap); an abort at
    // edge m_stop cuts everything from that edge on.
    task automatic check_now(input string tag);
        int  n, s, pi;
        bit  high, dn, bs;
        n = cyc;
        high = 0;
        pi = 0;
        for (int p = 0; p < m_ce; p++) begin
            s = m_k + 1 + m_d + p * (m_le + m_g);
            if (n >= s && n < s + m_le && n < m_stop) high = 1;
            if (s + m_le <= n && s + m_le < m_stop) pi++;
        end
        dn = (n == m_end) && (m_end < m_stop);
        bs = (n < m_end) && (n < m_stop);
        chk({tag, ".ge"},    32'(glitch_enable),          32'(high && m_mode == 0));
        chk({tag, ".gs"},    32'(glitch_enable_specific), 32'(high && m_mode == 1));
        chk({tag, ".done"},  32'(done),      32'(dn));
        chk({tag, ".busy"},  32'(busy),      32'(bs));
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(!bs));
        chk({tag, ".idx"},   32'(pulse_idx), 32'(pi));
    endtask

    // Offers a configuration at the next edge; called and returns at a negedge.
    task automatic apply_cfg(input int d, input int l, input int g, input int c,
                             input int m, input bit hold);
        cfg_delay = DW'(d);
        cfg_len   = LW'(l);
        cfg_gap   = LW'(g);
        cfg_count = LW'(c);
        cfg_mode  = m[0];
        cfg_valid = 1'b1;
        trigger   = hold;
        m_d    = d;
        m_le   = (l == 0) ? 1 : l;
        m_g    = g;
        m_ce   = (c == 0) ? 1 : c;
        m_mode = m;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // abort_off: 0 = none, -1 = random point in the campaign, >0 = edges after trigger.
    task automatic run_campaign(input string tag, input int d, input int l, input int g,
                                input int c, input int m, input int pre, input bit hold,
                                input int abort_off, input int tail);
        int last, aoff;
        apply_cfg(d, l, g, c, m, hold);
        chk({tag, ".armed_busy"},  32'(busy), 1);
        chk({tag, ".armed_ready"}, 32'(cfg_ready), 0);
        chk({tag, ".armed_idx"},   32'(pulse_idx), 0);
        if (!hold) begin
            for (int i = 0; i < pre; i++) begin
                @(negedge clk);
                chk({tag, ".wait_ge"},   32'(glitch_enable | glitch_enable_specific), 0);
                chk({tag, ".wait_busy"}, 32'(busy), 1);
            end
            trigger = 1'b1;
        end
        m_k   = cyc + 1;
        m_end = m_k + 1 + m_d + (m_ce - 1) * (m_le + m_g) + m_le;
        aoff  = (abort_off < 0) ? $urandom_range(m_end - m_k, 1) : abort_off;
        m_stop = (aoff > 0) ? m_k + aoff : NEVER;
        last   = ((aoff > 0) ? m_stop : m_end) + tail;
        while (cyc < last) begin
            abort = (cyc + 1 == m_stop);
            @(negedge clk);
            if (!hold) trigger = 1'b0;
            check_now(tag);
        end
        abort   = 1'b0;
        trigger = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_delay = '0;
        cfg_len   = '0;
        cfg_gap   = '0;
        cfg_count = '0;
        cfg_mode  = 1'b0;
        trigger   = 1'b0;
        abort     = 1'b0;
        m_k = 0; m_d = 0; m_le = 1; m_g = 0; m_ce = 1; m_mode = 0; m_end = 0; m_stop = NEVER;

        repeat (2) @(negedge clk);
        chk_quiet("reset", 0);
        reset = 1'b0;

        // Trigger without a configuration does nothing.
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        chk_quiet("idle_trig", 0);

        run_campaign("t1_single",   3, 2, 0, 1, 0, 2, 1'b0, 0, 3);
        run_campaign("t2_spaced",   0, 1, 2, 3, 1, 1, 1'b0, 0, 3);
        run_campaign("t3_b2b",      2, 2, 0, 2, 0, 0, 1'b0, 0, 3);
        run_campaign("t4_abort",    2, 2, 3, 4, 1, 1, 1'b0, 12, 3);
        chk("t4_abort.idx_final", 32'(pulse_idx), 2);
        run_campaign("t5_hold",     1, 2, 1, 2, 0, 0, 1'b1, 0, 6);
        run_campaign("zero_fields", 0, 0, 3, 0, 1, 0, 1'b0, 0, 2);

        // Abort and an offered config in the same cycle: config dropped.
        cfg_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        abort     = 1'b0;
        chk("abort_cfg.busy",  32'(busy), 0);
        chk("abort_cfg.ready", 32'(cfg_ready), 1);
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        chk("abort_cfg.ge",   32'(glitch_enable | glitch_enable_specific), 0);
        chk("abort_cfg.busy2", 32'(busy), 0);

        for (int r = 0; r < 12; r++) begin
            run_campaign("rand",
                         int'($urandom_range(12, 0)), int'($urandom_range(4, 0)),
                         int'($urandom_range(3, 0)),  int'($urandom_range(4, 0)),
                         int'($urandom_range(1, 0)),  int'($urandom_range(3, 0)),
                         1'b0, ($urandom_range(3, 0) == 0) ? -1 : 0, 2);
        end

        run_campaign("max_delay", (1 << DW) - 1, 1, 0, 1, 0, 0, 1'b0, 0, 2);

        // Asynchronous reset in the middle of a pulse.
        run_campaign("pre_rst", 1, 6, 0, 1, 1, 0, 1'b0, 5, 0);
        apply_cfg(1, 6, 0, 1, 1, 1'b0);
        trigger = 1'b1;
        m_k = cyc + 1;
        m_end = m_k + 1 + m_d + m_le;
        m_stop = NEVER;
        while (cyc < m_k + 4) begin
            @(negedge clk);
            trigger = 1'b0;
            check_now("rst_mid");
        end
        chk("rst_mid.gs_high", 32'(glitch_enable_specific), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst.gs", 32'(glitch_enable_specific), 0);
        chk("async_rst.ge", 32'(glitch_enable), 0);
        @(negedge clk);
        chk_quiet("rst_held", 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("rst_released", 0);
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        chk_quiet("rst_idle_trig", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glitch_scheduler.md
GLITCH_SCHEDULER -- requirements
Module: glitch_scheduler

Interface
REQ-001 Parameter DELAY_W, default 16, width of the trigger-to-first-glitch delay field.
REQ-002 Parameter LEN_W, default 8, width of the pulse-length, gap and pulse-count fields.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port cfg_valid, input, 1, a campaign configuration is offered.
REQ-006 Port cfg_ready, output, 1, the scheduler can accept a configuration.
REQ-007 Port cfg_delay, input, DELAY_W, cycles from trigger to first pulse.
REQ-008 Port cfg_len, input, LEN_W, cycles per glitch pulse.
REQ-009 Port cfg_gap, input, LEN_W, idle cycles between pulses.
REQ-010 Port cfg_count, input, LEN_W, number of pulses in the campaign.
REQ-011 Port cfg_mode, input, 1, 0 = random corruption, 1 = fixed-pattern corruption.
REQ-012 Port trigger, input, 1, start event, e.g. a core reaching a target instruction.
REQ-013 Port abort, input, 1, cancel any campaign in progress.
REQ-014 Port glitch_enable, output, 1, drives the injector random-corruption enable.
REQ-015 Port glitch_enable_specific, output, 1, drives the injector fixed-pattern enable.
REQ-016 Port busy, output, 1, a campaign is accepted and not yet finished.
REQ-017 Port done, output, 1, one-cycle pulse at campaign completion.
REQ-018 Port pulse_idx, output, LEN_W, number of pulses fully delivered in the current campaign.

Function
REQ-019 The block SHALL implement FSM states IDLE, ARMED, DELAY, GLITCH and GAP.
REQ-020 cfg_ready SHALL be 1 only in IDLE; a handshake (cfg_valid & cfg_ready) SHALL latch all cfg_* fields, clear pulse_idx and move to ARMED.
REQ-021 cfg_len = 0 and cfg_count = 0 SHALL each be treated as 1.
REQ-022 In ARMED, trigger sampled high at edge k SHALL load the delay counter and move to DELAY; trigger in any other state SHALL be ignored.
REQ-023 With trigger sampled at edge k, the glitch output SHALL first be high in the cycle after edge k+1+cfg_delay (cfg_delay = 0 gives 1 cycle of latency).
REQ-024 GLITCH SHALL last exactly cfg_len cycles; only the output selected by cfg_mode SHALL be high, and never both.
REQ-025 At the end of each pulse pulse_idx SHALL increment; if pulse_idx reaches cfg_count the FSM SHALL return to IDLE and done SHALL be high for that one cycle.
REQ-026 Otherwise the FSM SHALL go to GAP for cfg_gap cycles, then to GLITCH; cfg_gap = 0 SHALL give back-to-back pulses, with the output continuously high.
REQ-027 glitch_enable and glitch_enable_specific SHALL be registered outputs driven by the FSM only, with no combinational path from any input.
REQ-028 busy SHALL be 1 in ARMED, DELAY, GLITCH and GAP.
REQ-029 abort sampled high SHALL force IDLE at that edge and clear both glitch outputs at that edge; done SHALL NOT pulse; pulse_idx SHALL hold its value.
REQ-030 abort and a cfg handshake in the same cycle: abort SHALL win and the configuration SHALL be dropped.
REQ-031 The counters SHALL never wrap; a cfg_delay of all-ones SHALL delay by exactly 2^DELAY_W-1 cycles plus the latency defined in REQ-023.

Reset
REQ-032 While reset is high, the FSM SHALL be IDLE and cfg_ready=1; glitch_enable, glitch_enable_specific, busy, done and pulse_idx SHALL be 0, and the latched configuration SHALL be cleared.
REQ-033 Reset asserted during GLITCH SHALL drop both glitch outputs immediately, without waiting for a clock edge.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until a cfg handshake occurs.

Verification
REQ-035 Test 1: cfg delay=3, len=2, gap=0, count=1, mode=0, then trigger at edge 10 -> glitch_enable high in cycles 14-15, done pulses at edge 16, and glitch_enable_specific stays 0.
REQ-036 Test 2: cfg len=1, gap=2, count=3, mode=1 -> three one-cycle glitch_enable_specific pulses spaced 3 cycles apart, and pulse_idx steps 1, 2, 3.
REQ-037 Test 3: cfg len=2, gap=0, count=2 -> output high for 4 continuous cycles, with a single done pulse at the end.
REQ-038 Test 4: abort during the second GAP of a 4-pulse campaign -> outputs stay 0, done is never asserted, pulse_idx = 2, and cfg_ready = 1 on the next cycle.
REQ-039 Test 5: trigger held high through ARMED and the whole campaign -> only one campaign runs; trigger again after done, with no new cfg, -> no pulse.
REQ-040 Test 6: async reset asserted mid-GLITCH between clock edges -> outputs go low immediately, and all REQ-032 values hold after release.
